// File: rtl/line_clear_pkg.sv
// Shared playfield constants, FSM state type and mask helpers for the line-clear path.
package line_clear_pkg;

  localparam int unsigned ROWS      = 20;
  localparam int unsigned COLS      = 12;
  localparam int unsigned SCORE_MAX = 99;

  // Row index width and a counter width that can hold ROWS itself.
  localparam int unsigned IDX_W = $clog2(ROWS);
  localparam int unsigned CNT_W = $clog2(ROWS + 1);

  typedef logic [COLS-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    FLASH,
    COLLAPSE,
    DONE
  } state_e;

  // Number of set bits in a row mark mask.
  function automatic logic [CNT_W-1:0] popcount(input logic [ROWS-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < ROWS; i++) begin
      c = c + CNT_W'(m[i]);
    end
    return c;
  endfunction

  // Widen a per-row mask to a full playfield bit mask.
  function automatic logic [ROWS*COLS-1:0] expand_mask(input logic [ROWS-1:0] m);
    logic [ROWS*COLS-1:0] e;
    e = '0;
    for (int i = 0; i < ROWS; i++) begin
      e[i*COLS +: COLS] = {COLS{m[i]}};
    end
    return e;
  endfunction

endpackage

// File: rtl/row_compactor.sv
// Bottom-up in-place row compaction: skips marked rows, copies the rest downward,
// then zero-fills the rows left free at the top. Issues one board write per cycle.
module row_compactor
  import line_clear_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              en,
  input  logic [ROWS-1:0]   mark,
  input  row_t              rd_row,
  output logic [IDX_W-1:0]  rd_idx,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output row_t              wr_data,
  output logic              last
);

  // Pointers kept as "rows remaining" so that exhaustion is simply zero.
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] wr_cnt;
  logic             rd_step;
  logic             wr_step;
  logic             rd_valid;

  // Decide this cycle's move: skip a marked row, copy a kept row, or zero-fill.
  always_comb begin
    rd_valid = (rd_cnt != '0);
    rd_idx   = IDX_W'(rd_cnt - 1'b1);
    wr_idx   = IDX_W'(wr_cnt - 1'b1);
    wr_en    = 1'b0;
    wr_data  = '0;
    rd_step  = 1'b0;
    wr_step  = 1'b0;
    if (en) begin
      if (rd_valid) begin
        rd_step = 1'b1;
        if (!mark[rd_idx]) begin
          wr_en   = 1'b1;
          wr_data = rd_row;
          wr_step = 1'b1;
        end
      end else if (wr_cnt != '0) begin
        wr_en   = 1'b1;
        wr_step = 1'b1;
      end
    end
    last = wr_en && (wr_cnt == CNT_W'(1));
  end

  // Pointer registers; reloaded at the top of the field when a pass starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (init) begin
      rd_cnt <= CNT_W'(ROWS);
      wr_cnt <= CNT_W'(ROWS);
    end else begin
      if (rd_step) rd_cnt <= rd_cnt - 1'b1;
      if (wr_step) wr_cnt <= wr_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/line_clear_engine.sv
// Line-clear stage: scans the locked field for full rows, blinks them, collapses them
// out and updates the saturating score. Drives the display board/flash/score inputs.
module line_clear_engine
  import line_clear_pkg::*;
#(
  parameter int unsigned FLASH_TICKS = 4,
  parameter int unsigned SCORE_W     = 7
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  start,
  input  logic [ROWS*COLS-1:0]  board_in,
  input  logic                  score_clr,
  output logic [ROWS*COLS-1:0]  board_out,
  output logic [ROWS*COLS-1:0]  flash,
  output logic [SCORE_W-1:0]    score,
  output logic [CNT_W-1:0]      lines_cleared,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned TCNT_W = $clog2(FLASH_TICKS + 1);
  localparam logic [TCNT_W-1:0] TickLast = TCNT_W'(FLASH_TICKS - 1);

  state_e            state;
  row_t              board [ROWS];
  logic [ROWS-1:0]   mark;
  logic [IDX_W-1:0]  r;
  logic              phase;
  logic [TCNT_W-1:0] tcnt;
  logic [CNT_W-1:0]  k;

  logic              row_full;
  logic [ROWS-1:0]   mark_scan;
  logic [CNT_W-1:0]  k_scan;
  logic [SCORE_W:0]  score_sum;
  logic [SCORE_W-1:0] score_next;

  logic              cmp_init;
  logic              cmp_en;
  logic [IDX_W-1:0]  cmp_rd_idx;
  row_t              cmp_rd_row;
  logic              cmp_wr_en;
  logic [IDX_W-1:0]  cmp_wr_idx;
  row_t              cmp_wr_data;
  logic              cmp_last;

  assign busy = (state != IDLE);

  // Scan step result and saturating score sum (one extra bit before the clamp).
  always_comb begin
    row_full  = &board[r];
    mark_scan = row_full ? (mark | (ROWS'(1) << r)) : mark;
    k_scan    = popcount(mark_scan);
    score_sum = {1'b0, score} + (SCORE_W + 1)'(k);
    if (score_sum > (SCORE_W + 1)'(SCORE_MAX)) begin
      score_next = SCORE_W'(SCORE_MAX);
    end else begin
      score_next = score_sum[SCORE_W-1:0];
    end
  end

  // Flatten the board register for the display.
  always_comb begin
    board_out = '0;
    for (int i = 0; i < ROWS; i++) begin
      board_out[i*COLS +: COLS] = board[i];
    end
  end

  assign cmp_init   = (state == IDLE) && start;
  assign cmp_en     = (state == COLLAPSE);
  assign cmp_rd_row = board[cmp_rd_idx];

  row_compactor u_row_compactor (
    .clk     (clk),
    .reset   (reset),
    .init    (cmp_init),
    .en      (cmp_en),
    .mark    (mark),
    .rd_row  (cmp_rd_row),
    .rd_idx  (cmp_rd_idx),
    .wr_en   (cmp_wr_en),
    .wr_idx  (cmp_wr_idx),
    .wr_data (cmp_wr_data),
    .last    (cmp_last)
  );

  // Pass sequencer: state, board register, marks, flash timer, score and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      for (int i = 0; i < ROWS; i++) board[i] <= '0;
      mark          <= '0;
      r             <= '0;
      phase         <= 1'b0;
      tcnt          <= '0;
      k             <= '0;
      flash         <= '0;
      score         <= '0;
      lines_cleared <= '0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < ROWS; i++) board[i] <= board_in[i*COLS +: COLS];
            mark  <= '0;
            r     <= IDX_W'(ROWS - 1);
            state <= SCAN;
          end
        end
        SCAN: begin
          mark <= mark_scan;
          if (r == '0) begin
            k <= k_scan;
            if (k_scan == '0) begin
              state <= DONE;
            end else begin
              phase <= 1'b0;
              tcnt  <= '0;
              flash <= expand_mask(mark_scan);
              state <= FLASH;
            end
          end else begin
            r <= r - 1'b1;
          end
        end
        FLASH: begin
          if (tick) begin
            phase <= ~phase;
            tcnt  <= tcnt + 1'b1;
            if (tcnt == TickLast) begin
              flash <= '0;
              state <= COLLAPSE;
            end else begin
              // Rows are lit when the toggled phase returns to 0.
              flash <= phase ? expand_mask(mark) : '0;
            end
          end
        end
        COLLAPSE: begin
          if (cmp_wr_en) board[cmp_wr_idx] <= cmp_wr_data;
          if (cmp_last) state <= DONE;
        end
        DONE: begin
          done          <= 1'b1;
          lines_cleared <= k;
          score         <= score_next;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // A new-game clear overrides any score update in the same cycle.
      if (score_clr) score <= '0;
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Bench for line_clear_engine: directed scenarios plus random boards, checked against a
// row-filtering reference model and a cycle-timing model of scan/flash/collapse.
module tb_line_clear_engine;
  import line_clear_pkg::*;

  localparam int FT = 4;
  localparam int SW = 7;
  localparam int W  = ROWS * COLS;

  logic             clk = 1'b0;
  logic             reset, tick, start, score_clr;
  logic [W-1:0]     board_in;
  logic [W-1:0]     board_out, flash;
  logic [SW-1:0]    score;
  logic [CNT_W-1:0] lines_cleared;
  logic             busy, done;

  int checks = 0;
  int errors = 0;
  int score_m = 0;

  line_clear_engine #(.FLASH_TICKS(FT), .SCORE_W(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .start         (start),
    .board_in      (board_in),
    .score_clr     (score_clr),
    .board_out     (board_out),
    .flash         (flash),
    .score         (score),
    .lines_cleared (lines_cleared),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: keep non-full rows bottom-up, stack them at the bottom, zero the rest.
  function automatic logic [W-1:0] model_collapse(input logic [W-1:0] b, output int k);
    row_t q[$];
    row_t row;
    logic [W-1:0] o;
    o = '0;
    for (int rr = ROWS - 1; rr >= 0; rr--) begin
      row = b[rr*COLS +: COLS];
      if (row !== {COLS{1'b1}}) q.push_back(row);
    end
    k = ROWS - q.size();
    for (int i = 0; i < q.size(); i++) o[(ROWS-1-i)*COLS +: COLS] = q[i];
    return o;
  endfunction

  function automatic logic [W-1:0] model_mask(input logic [W-1:0] b);
    logic [W-1:0] m;
    m = '0;
    for (int rr = 0; rr < ROWS; rr++) begin
      if (b[rr*COLS +: COLS] === {COLS{1'b1}}) m[rr*COLS +: COLS] = {COLS{1'b1}};
    end
    return m;
  endfunction

  function automatic logic [W-1:0] set_row(input logic [W-1:0] b, input int rr, input row_t v);
    logic [W-1:0] o;
    o = b;
    o[rr*COLS +: COLS] = v;
    return o;
  endfunction

  // One full pass with random ticks; checks flash, busy, done timing and final results.
  task automatic run_pass(input logic [W-1:0] b, input bit clr_at_done, input string tag);
    logic [W-1:0] exp_b, msk, exp_f;
    int k, nt, tedge, dedge;
    bit tk, seen_done;
    exp_b = model_collapse(b, k);
    msk   = model_mask(b);
    board_in = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("%s latch", tag), board_out, b);
    nt = 0; tedge = -1; seen_done = 1'b0;
    for (int n = 1; n <= 400 && !seen_done; n++) begin
      tk    = ($urandom_range(0, 2) == 0);
      tick  = tk;
      dedge = (k == 0) ? ROWS + 1 : ((tedge >= 0) ? tedge + ROWS + k + 1 : -1);
      score_clr = clr_at_done && (n == dedge);
      @(posedge clk); #1;
      tick = 1'b0;
      score_clr = 1'b0;
      if (k > 0 && n > ROWS && tedge < 0 && tk) begin
        nt++;
        if (nt == FT) tedge = n;
      end
      if (k == 0 || n < ROWS || tedge >= 0) exp_f = '0;
      else exp_f = (nt % 2 == 0) ? msk : '0;
      check($sformatf("%s flash@%0d", tag, n), flash, exp_f);
      check($sformatf("%s done@%0d", tag, n), W'(done), W'(n == dedge));
      if (n == dedge) begin
        seen_done = 1'b1;
        if (clr_at_done) score_m = 0;
        else score_m = (score_m + k > SCORE_MAX) ? SCORE_MAX : score_m + k;
        check($sformatf("%s board", tag), board_out, exp_b);
        check($sformatf("%s lines", tag), W'(lines_cleared), W'(k));
        check($sformatf("%s score", tag), W'(score), W'(score_m));
        check($sformatf("%s idle", tag), W'(busy), W'(0));
      end else begin
        check($sformatf("%s busy@%0d", tag, n), W'(busy), W'(1));
      end
    end
    check($sformatf("%s done_seen", tag), W'(seen_done), W'(1));
  endtask

  task automatic pulse_clr();
    score_clr = 1'b1;
    @(posedge clk); #1;
    score_clr = 1'b0;
    score_m = 0;
    check("score_clr", W'(score), W'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] b, ba, bb;
    reset = 1'b1; tick = 1'b0; start = 1'b0; score_clr = 1'b0; board_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst board", board_out, '0);
    check("rst flash", flash, '0);
    check("rst score", W'(score), W'(0));
    check("rst lines", W'(lines_cleared), W'(0));
    check("rst busy", W'(busy), W'(0));
    check("rst done", W'(done), W'(0));
    reset = 1'b0;

    // Empty board: no flash, done after ROWS+1 cycles.
    run_pass('0, 1'b0, "empty");

    // Bottom row full, row above partial.
    b = set_row('0, 19, 12'hFFF);
    b = set_row(b, 18, 12'h0F0);
    run_pass(b, 1'b0, "single");

    // Two separated full rows with partial rows between and above.
    b = set_row('0, 5, 12'hFFF);
    b = set_row(b, 10, 12'hFFF);
    b = set_row(b, 7, 12'h801);
    b = set_row(b, 3, 12'h00F);
    run_pass(b, 1'b0, "split");

    // Preload the score to 97 using full-board passes.
    pulse_clr();
    for (int i = 0; i < 4; i++) run_pass({W{1'b1}}, 1'b0, "fullboard");
    b = {W{1'b1}};
    for (int rr = 0; rr < 3; rr++) b = set_row(b, rr, row_t'(12'h5A5 + rr));
    run_pass(b, 1'b0, "seventeen");

    // Four bottom rows full on top of a score of 97: saturates at 99.
    b = '0;
    for (int rr = 0; rr < 16; rr++) b = set_row(b, rr, row_t'($urandom_range(0, 12'hFFE)));
    for (int rr = 16; rr < ROWS; rr++) b = set_row(b, rr, 12'hFFF);
    run_pass(b, 1'b0, "saturate");

    // Ignored restart while busy, then reset in the middle of FLASH.
    ba = set_row('0, 19, 12'hFFF);
    ba = set_row(ba, 0, 12'h123);
    bb = {W{1'b1}};
    board_in = ba;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    board_in = bb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start board", board_out, ba);
    repeat (17) begin @(posedge clk); #1; end
    check("preflash busy", W'(busy), W'(1));
    check("preflash flash", flash, model_mask(ba));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    score_m = 0;
    check("midreset busy", W'(busy), W'(0));
    check("midreset flash", flash, '0);
    check("midreset board", board_out, '0);
    check("midreset score", W'(score), W'(0));

    // Score clear landing on the done cycle wins over the update.
    run_pass(set_row('0, 12, 12'hFFF), 1'b0, "one");
    run_pass(set_row(set_row('0, 19, 12'hFFF), 4, 12'h3C3), 1'b1, "clr_done");

    // Random boards.
    for (int t = 0; t < 6; t++) begin
      b = '0;
      for (int rr = 0; rr < ROWS; rr++) begin
        if ($urandom_range(0, 3) == 0) b = set_row(b, rr, 12'hFFF);
        else b = set_row(b, rr, row_t'($urandom()));
      end
      run_pass(b, 1'b0, $sformatf("rand%0d", t));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
